// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Hazard/flush/halt controller for a 5-stage in-order pipeline
//            without forwarding. A 3-slot scoreboard (EXE, MEM, WB) tracks
//            in-flight destinations; RAW hazards stall IF/ID and bubble
//            ID_EXE, taken branches flush IF_ID, HALT drains and parks.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_LEN = 5,
  parameter int CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    id_valid,
  input  logic [REG_ADDR_LEN-1:0] id_rs1,
  input  logic                    id_rs1_en,
  input  logic [REG_ADDR_LEN-1:0] id_rs2,
  input  logic                    id_rs2_en,
  input  logic [REG_ADDR_LEN-1:0] id_rd,
  input  logic                    id_rd_en,
  input  logic                    id_is_halt,
  input  logic                    exe_branch_taken,
  output logic                    stall_if,
  output logic                    bubble_id_exe,
  output logic                    flush_if_id,
  output logic                    issue,
  output logic                    halt,
  output logic [CNT_W-1:0]        stall_cycles
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Scoreboard slots: index 0 = EXE, 1 = MEM, 2 = WB.
  logic [2:0]                   r_slot_v;
  logic [2:0]                   r_slot_rd_en;
  logic [2:0]                   r_slot_halt;
  logic [2:0][REG_ADDR_LEN-1:0] r_slot_rd;

  logic w_match1;
  logic w_match2;
  logic w_hazard;
  logic w_wb_halt;
  logic w_count_en;

  // Source-vs-scoreboard match; WB is included because the register file
  // write is not visible to the same-cycle ID read. r0 never matches.
  always_comb begin
    w_match1 = 1'b0;
    w_match2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (r_slot_v[i] && r_slot_rd_en[i] && (r_slot_rd[i] == id_rs1)) w_match1 = 1'b1;
      if (r_slot_v[i] && r_slot_rd_en[i] && (r_slot_rd[i] == id_rs2)) w_match2 = 1'b1;
    end
    if (id_rs1 == '0) w_match1 = 1'b0;
    if (id_rs2 == '0) w_match2 = 1'b0;
  end

  assign w_hazard  = id_valid & ((id_rs1_en & w_match1) | (id_rs2_en & w_match2));
  assign w_wb_halt = r_slot_v[2] & r_slot_halt[2];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_next_state;
  end

  // Next-state and pipeline control outputs; flush wins over stall.
  always_comb begin
    w_next_state  = r_state;
    stall_if      = 1'b0;
    bubble_id_exe = 1'b0;
    flush_if_id   = 1'b0;
    issue         = 1'b0;
    w_count_en    = 1'b0;
    case (r_state)
      RUN: begin
        flush_if_id   = exe_branch_taken;
        stall_if      = w_hazard & ~exe_branch_taken;
        bubble_id_exe = w_hazard | exe_branch_taken;
        issue         = id_valid & ~w_hazard & ~exe_branch_taken;
        w_count_en    = w_hazard & ~exe_branch_taken;
        if (issue && id_is_halt) w_next_state = DRAIN;
      end
      DRAIN: begin
        // No older branch can still be in EXE here, so the branch input is ignored.
        stall_if      = 1'b1;
        bubble_id_exe = 1'b1;
        if (w_wb_halt) w_next_state = HALTED;
      end
      HALTED: begin
        stall_if      = 1'b1;
        bubble_id_exe = 1'b1;
      end
      default: w_next_state = RUN;
    endcase
  end

  // Scoreboard shift chain; non-issuing cycles push an invalid entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_v     <= '0;
      r_slot_rd_en <= '0;
      r_slot_halt  <= '0;
      r_slot_rd    <= '0;
    end else begin
      r_slot_v     <= {r_slot_v[1:0], issue};
      r_slot_rd_en <= {r_slot_rd_en[1:0], issue & id_rd_en};
      r_slot_halt  <= {r_slot_halt[1:0], issue & id_is_halt};
      r_slot_rd    <= {r_slot_rd[1:0], id_rd};
    end
  end

  // Halt flag rises as the HALT instruction retires from WB and stays set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              halt <= 1'b0;
    else if ((r_state == DRAIN) && w_wb_halt) halt <= 1'b1;
  end

  // Saturating count of hazard-stall cycles in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (w_count_en && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Self-checking bench for pipe_hazard_ctrl. A reference model keeps
//            a list of issued writers with their issue cycle and the HALT issue
//            cycle, and derives expected outputs from cycle distances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int RA  = 5;
  localparam int CW  = 16;
  localparam int CWS = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          id_valid = 1'b0;
  logic [RA-1:0] id_rs1 = '0;
  logic          id_rs1_en = 1'b0;
  logic [RA-1:0] id_rs2 = '0;
  logic          id_rs2_en = 1'b0;
  logic [RA-1:0] id_rd = '0;
  logic          id_rd_en = 1'b0;
  logic          id_is_halt = 1'b0;
  logic          exe_branch_taken = 1'b0;

  logic           stall_if, bubble_id_exe, flush_if_id, issue, halt;
  logic [CW-1:0]  stall_cycles;
  logic           s_stall_if, s_bubble, s_flush, s_issue, s_halt;
  logic [CWS-1:0] s_stall_cycles;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_ADDR_LEN(RA), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs1_en(id_rs1_en), .id_rs2(id_rs2), .id_rs2_en(id_rs2_en),
    .id_rd(id_rd), .id_rd_en(id_rd_en), .id_is_halt(id_is_halt),
    .exe_branch_taken(exe_branch_taken),
    .stall_if(stall_if), .bubble_id_exe(bubble_id_exe), .flush_if_id(flush_if_id),
    .issue(issue), .halt(halt), .stall_cycles(stall_cycles)
  );

  // Narrow-counter copy on the same stimulus, to reach saturation quickly.
  pipe_hazard_ctrl #(.REG_ADDR_LEN(RA), .CNT_W(CWS)) dut_small (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs1_en(id_rs1_en), .id_rs2(id_rs2), .id_rs2_en(id_rs2_en),
    .id_rd(id_rd), .id_rd_en(id_rd_en), .id_is_halt(id_is_halt),
    .exe_branch_taken(exe_branch_taken),
    .stall_if(s_stall_if), .bubble_id_exe(s_bubble), .flush_if_id(s_flush),
    .issue(s_issue), .halt(s_halt), .stall_cycles(s_stall_cycles)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state.
  int t       = 0;    // current cycle index
  int wq_cyc[$];      // issue cycle of each register writer
  int wq_rd[$];       // destination of each register writer
  int halt_at = -1;   // cycle in which HALT issued, -1 if none
  int m_cnt   = 0;    // unsaturated stall count since reset

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, t, got, exp);
    end
  endtask

  // A register is busy while its writer issued 1..3 cycles ago.
  function automatic bit m_busy(input int rs);
    if (rs == 0) return 1'b0;
    foreach (wq_cyc[i])
      if ((t - wq_cyc[i] >= 1) && (t - wq_cyc[i] <= 3) && (wq_rd[i] == rs)) return 1'b1;
    return 1'b0;
  endfunction

  // Drive one ID cycle, compare all outputs with the model, then clock.
  task automatic step(input bit v, input int rs1, input bit e1, input int rs2, input bit e2,
                      input int rd, input bit de, input bit h, input bit br);
    bit run, haz, fl, st, bb, iss, hl;
    int sat;
    id_valid = v; id_rs1 = rs1[RA-1:0]; id_rs1_en = e1;
    id_rs2 = rs2[RA-1:0]; id_rs2_en = e2; id_rd = rd[RA-1:0]; id_rd_en = de;
    id_is_halt = h; exe_branch_taken = br;
    #1;
    run = (halt_at < 0) || (t <= halt_at);
    hl  = (halt_at >= 0) && (t >= halt_at + 4);
    if (run) begin
      haz = v && ((e1 && m_busy(rs1)) || (e2 && m_busy(rs2)));
      fl  = br;
      st  = haz && !br;
      bb  = haz || br;
      iss = v && !haz && !br;
    end else begin
      fl = 1'b0; st = 1'b1; bb = 1'b1; iss = 1'b0;
    end
    sat = (m_cnt > 15) ? 15 : m_cnt;
    check_val("stall_if", stall_if, st);
    check_val("bubble_id_exe", bubble_id_exe, bb);
    check_val("flush_if_id", flush_if_id, fl);
    check_val("issue", issue, iss);
    check_val("halt", halt, hl);
    check_val("stall_cycles", stall_cycles, m_cnt);
    check_val("stall_cycles_sat4", s_stall_cycles, sat);
    @(posedge clk);
    if (run && st) m_cnt++;
    if (iss && de) begin wq_cyc.push_back(t); wq_rd.push_back(rd); end
    if (iss && h) halt_at = t;
    while (wq_cyc.size() > 0 && (t - wq_cyc[0] > 3)) begin
      void'(wq_cyc.pop_front()); void'(wq_rd.pop_front());
    end
    t++;
    #1;
  endtask

  // Asynchronous reset pulse between clock edges; effects must be immediate.
  task automatic async_reset();
    id_valid = 1'b0; id_rs1_en = 1'b0; id_rs2_en = 1'b0; id_rd_en = 1'b0;
    id_is_halt = 1'b0; exe_branch_taken = 1'b0;
    rst_n = 1'b0;
    #1;
    wq_cyc.delete(); wq_rd.delete(); halt_at = -1; m_cnt = 0;
    check_val("rst_halt", halt, 0);
    check_val("rst_stall_cycles", stall_cycles, 0);
    check_val("rst_stall_if", stall_if, 0);
    check_val("rst_bubble", bubble_id_exe, 0);
    check_val("rst_flush", flush_if_id, 0);
    check_val("rst_issue", issue, 0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    t++;
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    async_reset();

    // Back-to-back RAW: 3 stalls, consumer issues on the 4th cycle.
    step(1, 1, 0, 2, 0, 3, 1, 0, 0);
    repeat (4) step(1, 3, 1, 0, 0, 8, 1, 0, 0);
    check_val("b2b_count", stall_cycles, 3);

    // Distance-2 RAW: 2 stalls.
    async_reset();
    step(1, 0, 0, 0, 0, 5, 1, 0, 0);
    step(1, 1, 1, 2, 1, 9, 1, 0, 0);
    repeat (3) step(1, 5, 1, 0, 0, 10, 1, 0, 0);
    check_val("dist2_count", stall_cycles, 2);

    // r0 writer/reader and disabled source: no stalls.
    async_reset();
    step(1, 0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 1, 0, 1, 3, 1, 0, 0);
    step(1, 0, 0, 3, 0, 4, 1, 0, 0);
    check_val("r0_count", stall_cycles, 0);

    // Taken branch while ID reader is hazarded: flushed, not stalled.
    async_reset();
    step(1, 0, 0, 0, 0, 4, 1, 0, 0);
    step(1, 4, 1, 0, 0, 7, 1, 0, 1);
    step(1, 7, 1, 0, 0, 11, 1, 0, 0);
    check_val("branch_count", stall_cycles, 0);

    // HALT drain with branch pulses ignored, then held.
    async_reset();
    step(1, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 7; i++) step(1, 1, 1, 2, 1, 6, 1, 0, i[0]);
    check_val("halt_held", halt, 1);

    // Reset in the middle of DRAIN.
    async_reset();
    step(1, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0, 2, 1, 0, 0);
    async_reset();
    step(1, 0, 0, 0, 0, 2, 1, 0, 0);

    // Long stall run: narrow counter saturates, wide one keeps counting.
    async_reset();
    for (int k = 0; k < 8; k++) begin
      step(1, 0, 0, 0, 0, 2, 1, 0, 0);
      repeat (4) step(1, 2, 1, 0, 0, 0, 0, 0, 0);
    end
    check_val("sat4_value", s_stall_cycles, 15);
    check_val("wide_value", stall_cycles, 24);

    // Randomized traffic with small register space to provoke hazards.
    async_reset();
    for (int n = 0; n < 4000; n++) begin
      if ((halt_at >= 0 && t > halt_at + 6) || ($urandom_range(0, 199) == 0)) async_reset();
      step($urandom_range(0, 7) != 0,
           $urandom_range(0, 3), $urandom_range(0, 1) != 0,
           $urandom_range(0, 3), $urandom_range(0, 1) != 0,
           $urandom_range(0, 3), $urandom_range(0, 1) != 0,
           $urandom_range(0, 59) == 0,
           $urandom_range(0, 7) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- In-order pipeline controller for the 5-stage IF/ID/EXE/MEM/WB datapath. The datapath has no forwarding.
- Tracks destination registers of in-flight instructions in a 3-slot scoreboard shift chain (EXE, MEM, WB).
- Stalls IF and IF_ID and injects bubbles into ID_EXE on RAW hazards.
- Flushes wrong-path instructions on a taken branch resolved in EXE.
- Drains the pipeline on HALT and holds it halted.

Parameters:
REG_ADDR_LEN, 5, register address width
CNT_W, 16, width of saturating stall-cycle counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active low
id_valid  in  1  IF_ID holds a valid instruction
id_rs1  in  REG_ADDR_LEN  ID source 1 address
id_rs1_en  in  1  source 1 is read
id_rs2  in  REG_ADDR_LEN  ID source 2 address
id_rs2_en  in  1  source 2 is read
id_rd  in  REG_ADDR_LEN  ID destination address
id_rd_en  in  1  ID instruction writes id_rd
id_is_halt  in  1  ID instruction is HALT
exe_branch_taken  in  1  instruction in EXE resolved as a taken branch
stall_if  out  1  hold PC and IF_ID contents
bubble_id_exe  out  1  ID_EXE loads NOP instead of ID output
flush_if_id  out  1  IF_ID loads NOP
issue  out  1  ID instruction advances into EXE this cycle
halt  out  1  pipeline drained and halted (registered)
stall_cycles  out  CNT_W  count of hazard-stall cycles, saturating

Behaviour:
- Scoreboard slots S_EXE, S_MEM, S_WB. Each slot holds: v, rd, rd_en, is_halt.
- Shift on every rising edge: S_WB<=S_MEM; S_MEM<=S_EXE; S_EXE<=issue ? {1,id_rd,id_rd_en,id_is_halt} : invalid.
- FSM states RUN, DRAIN, HALTED. Reset state is RUN.
- match(rs) = rs!=0 AND any slot with v & rd_en & rd==rs. Register r0 never causes a hazard. A WB write is not visible to the same-cycle ID read, so S_WB is included in the match.
- hazard = id_valid & ((id_rs1_en & match(id_rs1)) | (id_rs2_en & match(id_rs2))).
- Outputs in RUN (combinational):
  - flush = exe_branch_taken
  - flush_if_id = flush
  - stall_if = hazard & ~flush
  - bubble_id_exe = hazard | flush
  - issue = id_valid & ~hazard & ~flush
- Flush has priority over stall. A wrong-path instruction in ID is discarded, not stalled, and the stall counter does not increment.
- RUN->DRAIN on an edge where issue & id_is_halt. A HALT killed by a flush does not transition.
- Outputs in DRAIN: stall_if=1, bubble_id_exe=1, issue=0, flush_if_id=0. exe_branch_taken is ignored; no older branch can remain in EXE.
- DRAIN->HALTED on the edge where S_WB.v & S_WB.is_halt. halt<=1 on that same edge.
- HALTED: same outputs as DRAIN, halt=1. Only reset leaves HALTED.
- stall_cycles increments on each edge where stall_if=1 in RUN. It saturates at 2^CNT_W-1 and never wraps.
- Reset (async, any state, including mid-DRAIN or mid-stall): all slots invalid, state RUN, halt=0, stall_cycles=0.
- With id_valid=0 after reset, all combinational outputs are 0.
- Latency:
  - hazard to stall is the same cycle.
  - The consumer issues on the first cycle the producer has left S_WB: the 4th cycle after the producer's issue cycle, i.e. 3 stall cycles for back-to-back dependents.

Test Plan:
- Back-to-back RAW: issue ADD rd=r3, next cycle SUB rs1=r3 -> stall_if=1 and bubble=1 for exactly 3 cycles, SUB issues on the 4th cycle, stall_cycles=3.
- Distance-2 RAW: ADD rd=r5, one independent instruction, then reader of r5 -> 2 stall cycles, stall_cycles=2.
- r0 and disabled-source case: writer with rd=r0 followed by reader rs1=r0, plus a reader with rs2=r3 and rs2_en=0 after writer r3 -> 0 stalls, issue=1 each cycle.
- Branch with simultaneous hazard: exe_branch_taken=1 while ID has a stalled reader -> flush_if_id=1, bubble=1, stall_if=0, issue=0. S_EXE invalid next cycle; stall_cycles unchanged.
- HALT drain: HALT issues on edge E -> stall_if=1 from the next cycle; halt=1 after edge E+3, where the HALT is in S_WB. Pulsing exe_branch_taken during DRAIN has no effect; halt is held.
- Reset mid-DRAIN and stall counter saturation:
  - Assert rst_n=0 during DRAIN -> halt=0, state RUN, stall_cycles=0 immediately.
  - Force 65540 stall cycles (CNT_W=16) -> stall_cycles=16'hFFFF.
